cache_arbiter: RTL and testbench
================================

# cache_arbiter

Shares the single physical-memory line port between the instruction cache and the data cache of the pipelined RV32I core. It sits below both caches and above the cacheline adaptor. It serialises their line fills and write-backs with a registered round-robin FSM, and it holds the request stable toward memory for the full transaction. It also keeps per-requester grant counters for performance analysis.

## Interface
Parameters:
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, byte address width

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache line read request; held high until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request; held until d_resp
- d_write  in  1  D-cache line write-back request; held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write-back line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  line read to adaptor
- pmem_write  out  1  line write to adaptor
- pmem_addr  out  ADDR_W  registered transaction address
- pmem_wdata  out  LINE_W  registered write line
- pmem_rdata  in  LINE_W  line from adaptor
- pmem_resp  in  1  adaptor completion pulse
- busy  out  1  high in I_BUSY, D_BUSY and GAP
- i_grant_cnt  out  32  number of I-cache grants, wraps mod 2^32
- d_grant_cnt  out  32  number of D-cache grants, wraps mod 2^32

## Operation
- States:
  - IDLE: no transaction outstanding.
  - I_BUSY: serving an I-cache read.
  - D_BUSY: serving a D-cache read or write-back.
  - GAP: one dead cycle after a completion.
- last_grant register: 0 means I, 1 means D. Reset value is 0, so the first tie goes to D.
- In IDLE:
  - Pending I only (i_read) → I_BUSY.
  - Pending D only (d_read|d_write) → D_BUSY.
  - Both pending → grant the requester not equal to last_grant.
  - No request → stay in IDLE.
- On a grant:
  - Capture the requester's address, and d_wdata if it is a D write, into pmem_addr/pmem_wdata.
  - Capture the op: write = d_write.
  - Update last_grant.
  - Increment the matching grant counter.
- I_BUSY: pmem_read=1.
- D_BUSY: pmem_read=~op_write, pmem_write=op_write.
- d_read and d_write both high is illegal. The arbiter treats it as a write.
- In X_BUSY, pmem_resp=1 →
  - X_resp=1 in the same cycle (combinational).
  - X_rdata=pmem_rdata.
  - Next state is GAP.
- Otherwise the arbiter holds X_BUSY with pmem_addr/pmem_wdata/op unchanged. There is no timeout.
- GAP: no pmem strobe, no resp. Always → IDLE. This lets the served cache drop its request before re-arbitration.
- i_rdata/d_rdata: pmem_rdata is passed through at all times. Callers sample them only with their resp.
- pmem_resp while in IDLE or GAP is ignored. No resp is produced and there is no state change.
- A requester that deasserts mid-transaction does not abort it. The transaction completes, X_resp still pulses, and the counter is not decremented.
- Address/data inputs are ignored outside the grant cycle.

## Timing
- Reset (async, immediate) values:
  - state=IDLE, last_grant=0.
  - pmem_read=pmem_write=0, pmem_addr=0, pmem_wdata=0.
  - i_resp=d_resp=0, busy=0.
  - both counters=0.
- A reset in the middle of a transaction abandons it with no resp. The adaptor must be reset by the same rst.
- Strobes are decoded from the registered state, so there is no combinational path from request to pmem strobe.
- Cycle sequence for a grant:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: pmem strobe high.
  - Cycle N: pmem_resp and X_resp.
  - Cycle N+1: GAP.
  - Cycle N+2: IDLE, re-arbitration.
  - Cycle N+3: next strobe at the earliest.
- Minimum occupancy per transaction is 4 cycles (N=1).
- Under continuous contention, grants alternate I, D, I, D. Neither requester waits more than one transaction.

## Test plan
- Reset, then i_read=1, i_addr=0x0000_1040, adaptor resp after 5 cycles → pmem_read high from cycle 1 with pmem_addr=0x0000_1040; i_resp one pulse on cycle 5; i_grant_cnt=1; busy low by cycle 7.
- Reset, then i_read and d_read rise in the same cycle → D served first (pmem_addr=d_addr), then I, then D again if both still requesting; counters alternate.
- d_write=1, d_addr=0x8000_0020, d_wdata=all 0xA5, with d_wdata changed during the busy period → pmem_write=1 and pmem_wdata stays 0xA5..A5 for the whole transaction; d_resp pulses once.
- pmem_resp pulsed while in IDLE and in GAP → no i_resp/d_resp, state and counters unchanged.
- rst asserted 2 cycles into a D_BUSY read → same cycle: pmem_read=0, busy=0, counters=0; after release, a pending i_read is granted first (last_grant=0 means a tie goes to D, but only I is pending).
- Preload d_grant_cnt to 0xFFFF_FFFF (force) and grant D → counter wraps to 0.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Purpose: cache-side and memory-side line-port signals shared by the cache arbiter.
// Latency: none, wires only.
// Backpressure: requests are held by the caches until their resp; memory side completes on pmem_resp.
// Ports: slave = arbiter view (takes cache requests, drives pmem); master = caches + adaptor view.
interface cache_arbiter_if #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) ();
   // I-cache side
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   // D-cache side
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   // physical memory (cacheline adaptor) side
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_addr;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
   );
endinterface

// File: rtl/cache_arbiter.sv
// Purpose: round-robin arbiter sharing one pmem line port between the I-cache and the D-cache.
// Latency: strobe 1 cycle after the request is seen; resp is combinational with pmem_resp; one GAP cycle follows.
// Backpressure: a granted transaction is held stable until pmem_resp (no timeout); the loser waits in IDLE.
// Ports: clk, rst (async active-high), bus (cache_arbiter_if.slave), busy, i_grant_cnt, d_grant_cnt.
module cache_arbiter #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   cache_arbiter_if.slave bus,
   output logic           busy,
   output logic [31:0]    i_grant_cnt,
   output logic [31:0]    d_grant_cnt
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      GAP    = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last_grant;   // 0: I was served last, 1: D was served last
   logic              op_write;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              i_pend;
   logic              d_pend;
   logic              grant_i;
   logic              grant_d;

   assign i_pend = bus.i_read;
   // read+write together is treated as a write-back
   assign d_pend = bus.d_read | bus.d_write;

   // Read data is passed straight through; each cache qualifies it with its own resp.
   assign bus.i_rdata    = bus.pmem_rdata;
   assign bus.d_rdata    = bus.pmem_rdata;
   assign bus.pmem_addr  = addr_q;
   assign bus.pmem_wdata = wdata_q;
   assign busy           = (state != IDLE);

   always_comb begin
      state_nxt       = state;
      grant_i         = 1'b0;
      grant_d         = 1'b0;
      bus.pmem_read   = 1'b0;
      bus.pmem_write  = 1'b0;
      bus.i_resp      = 1'b0;
      bus.d_resp      = 1'b0;
      case (state)
         IDLE: begin
            // on a tie, serve whoever was not served last
            if (i_pend && d_pend) begin
               grant_i = last_grant;
               grant_d = ~last_grant;
            end else begin
               grant_i = i_pend;
               grant_d = d_pend;
            end
            if (grant_i) begin
               state_nxt = I_BUSY;
            end else if (grant_d) begin
               state_nxt = D_BUSY;
            end
         end
         I_BUSY: begin
            bus.pmem_read = 1'b1;
            if (bus.pmem_resp) begin
               bus.i_resp = 1'b1;
               state_nxt  = GAP;
            end
         end
         D_BUSY: begin
            bus.pmem_read  = ~op_write;
            bus.pmem_write = op_write;
            if (bus.pmem_resp) begin
               bus.d_resp = 1'b1;
               state_nxt  = GAP;
            end
         end
         GAP: begin
            // dead cycle lets the served cache drop its request before re-arbitration
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= 1'b0;
         op_write    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         i_grant_cnt <= 32'd0;
         d_grant_cnt <= 32'd0;
      end else begin
         state <= state_nxt;
         if (grant_i) begin
            addr_q      <= bus.i_addr;
            op_write    <= 1'b0;
            last_grant  <= 1'b0;
            i_grant_cnt <= i_grant_cnt + 32'd1;
         end
         if (grant_d) begin
            addr_q      <= bus.d_addr;
            op_write    <= bus.d_write;
            last_grant  <= 1'b1;
            d_grant_cnt <= d_grant_cnt + 32'd1;
            if (bus.d_write) begin
               wdata_q <= bus.d_wdata;
            end
         end
      end
   end
endmodule

// File: tb/tb_cache_arbiter.sv
// Purpose: directed self-checking bench for cache_arbiter.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 4 units after it.
// Backpressure: the bench plays both caches and the adaptor, pulsing pmem_resp on chosen cycles.
module tb_cache_arbiter;
   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        busy;
   logic [31:0] i_grant_cnt;
   logic [31:0] d_grant_cnt;
   int          vectors = 0;
   int          miscompares = 0;

   cache_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

   cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .busy        (busy),
      .i_grant_cnt (i_grant_cnt),
      .d_grant_cnt (d_grant_cnt)
   );

   always #5 clk = ~clk;

   // move to the start of the next cycle (just after the rising edge)
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // let combinational outputs settle, still before the next edge
   task automatic settle();
      #3;
   endtask

   task automatic idle_inputs();
      bus.i_read     = 1'b0;
      bus.i_addr     = '0;
      bus.d_read     = 1'b0;
      bus.d_write    = 1'b0;
      bus.d_addr     = '0;
      bus.d_wdata    = '0;
      bus.pmem_rdata = '0;
      bus.pmem_resp  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      step();
      rst = 1'b1;
      settle();
      vectors++; if (bus.pmem_read !== 1'b0) begin miscompares++; $display("FAIL rst_pmem_read: got %b expected 0", bus.pmem_read); end
      vectors++; if (bus.pmem_write !== 1'b0) begin miscompares++; $display("FAIL rst_pmem_write: got %b expected 0", bus.pmem_write); end
      vectors++; if (bus.pmem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_pmem_addr: got %h expected 0", bus.pmem_addr); end
      vectors++; if (bus.pmem_wdata !== 256'h0) begin miscompares++; $display("FAIL rst_pmem_wdata: got %h expected 0", bus.pmem_wdata); end
      vectors++; if ({bus.i_resp, bus.d_resp, busy} !== 3'b000) begin miscompares++; $display("FAIL rst_resp_busy: got %b expected 000", {bus.i_resp, bus.d_resp, busy}); end
      vectors++; if ({i_grant_cnt, d_grant_cnt} !== 64'h0) begin miscompares++; $display("FAIL rst_counters: got %h/%h expected 0/0", i_grant_cnt, d_grant_cnt); end
      step();
      rst = 1'b0;
      settle();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_release_busy: got %b expected 0", busy); end
   endtask

   task automatic test_single_read();
      logic [LINE_W-1:0] line;
      line = {8{32'h1234_5678}};
      do_reset();
      // cycle 0: request seen in IDLE, no combinational strobe
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_1040;
      settle();
      vectors++; if (bus.pmem_read !== 1'b0) begin miscompares++; $display("FAIL rd_c0_no_strobe: got %b expected 0", bus.pmem_read); end
      step(); settle();   // cycle 1
      vectors++; if (bus.pmem_read !== 1'b1) begin miscompares++; $display("FAIL rd_c1_strobe: got %b expected 1", bus.pmem_read); end
      vectors++; if (bus.pmem_addr !== 32'h0000_1040) begin miscompares++; $display("FAIL rd_c1_addr: got %h expected 00001040", bus.pmem_addr); end
      vectors++; if (i_grant_cnt !== 32'd1) begin miscompares++; $display("FAIL rd_c1_icnt: got %0d expected 1", i_grant_cnt); end
      vectors++; if ({busy, bus.i_resp, bus.pmem_write} !== 3'b100) begin miscompares++; $display("FAIL rd_c1_busy_resp: got %b expected 100", {busy, bus.i_resp, bus.pmem_write}); end
      step();             // cycle 2: address input changes, must be ignored
      bus.i_addr = 32'hDEAD_BEEF;
      step(); settle();   // cycle 3
      vectors++; if (bus.pmem_addr !== 32'h0000_1040) begin miscompares++; $display("FAIL rd_c3_addr_held: got %h expected 00001040", bus.pmem_addr); end
      step();             // cycle 4
      step();             // cycle 5: adaptor completes
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = line;
      settle();
      vectors++; if (bus.i_resp !== 1'b1) begin miscompares++; $display("FAIL rd_c5_iresp: got %b expected 1", bus.i_resp); end
      vectors++; if (bus.i_rdata !== line) begin miscompares++; $display("FAIL rd_c5_rdata: got %h expected %h", bus.i_rdata, line); end
      vectors++; if (bus.d_resp !== 1'b0) begin miscompares++; $display("FAIL rd_c5_dresp: got %b expected 0", bus.d_resp); end
      step();             // cycle 6: GAP
      bus.pmem_resp = 1'b0;
      bus.i_read    = 1'b0;
      settle();
      vectors++; if ({bus.i_resp, bus.pmem_read, busy} !== 3'b001) begin miscompares++; $display("FAIL rd_c6_gap: got %b expected 001", {bus.i_resp, bus.pmem_read, busy}); end
      step(); settle();   // cycle 7: IDLE
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_c7_busy: got %b expected 0", busy); end
      vectors++; if (i_grant_cnt !== 32'd1) begin miscompares++; $display("FAIL rd_c7_icnt: got %0d expected 1", i_grant_cnt); end
   endtask

   task automatic test_contention();
      // expected grant order after reset: D, I, D
      logic [31:0] exp_addr [3];
      logic [31:0] exp_icnt [3];
      logic [31:0] exp_dcnt [3];
      logic        exp_d    [3];
      exp_addr = '{32'h0000_3000, 32'h0000_2000, 32'h0000_3000};
      exp_icnt = '{32'd0, 32'd1, 32'd1};
      exp_dcnt = '{32'd1, 32'd1, 32'd2};
      exp_d    = '{1'b1, 1'b0, 1'b1};
      do_reset();
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_2000;
      bus.d_read = 1'b1;
      bus.d_addr = 32'h0000_3000;
      for (int k = 0; k < 3; k++) begin
         step();          // strobe cycle, completes at once (N=1)
         bus.pmem_resp = 1'b1;
         settle();
         vectors++; if (bus.pmem_read !== 1'b1) begin miscompares++; $display("FAIL cont%0d_strobe: got %b expected 1", k, bus.pmem_read); end
         vectors++; if (bus.pmem_addr !== exp_addr[k]) begin miscompares++; $display("FAIL cont%0d_addr: got %h expected %h", k, bus.pmem_addr, exp_addr[k]); end
         vectors++; if ({i_grant_cnt, d_grant_cnt} !== {exp_icnt[k], exp_dcnt[k]}) begin miscompares++; $display("FAIL cont%0d_cnts: got %0d/%0d expected %0d/%0d", k, i_grant_cnt, d_grant_cnt, exp_icnt[k], exp_dcnt[k]); end
         vectors++; if ({bus.i_resp, bus.d_resp} !== {~exp_d[k], exp_d[k]}) begin miscompares++; $display("FAIL cont%0d_resp: got %b expected %b", k, {bus.i_resp, bus.d_resp}, {~exp_d[k], exp_d[k]}); end
         step();          // GAP
         bus.pmem_resp = 1'b0;
         if (k == 2) begin
            bus.i_read = 1'b0;
            bus.d_read = 1'b0;
         end
         settle();
         vectors++; if ({busy, bus.pmem_read} !== 2'b10) begin miscompares++; $display("FAIL cont%0d_gap: got %b expected 10", k, {busy, bus.pmem_read}); end
         step(); settle(); // IDLE
         vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cont%0d_idle: got %b expected 0", k, busy); end
      end
      step(); settle();
      vectors++; if (bus.pmem_read !== 1'b0) begin miscompares++; $display("FAIL cont_quiet: got %b expected 0", bus.pmem_read); end
   endtask

   task automatic test_write_back();
      logic [LINE_W-1:0] a5;
      logic [LINE_W-1:0] c3;
      a5 = {32{8'hA5}};
      c3 = {32{8'hC3}};
      do_reset();
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h8000_0020;
      bus.d_wdata = a5;
      step();             // cycle 1: change inputs behind the captured copy
      bus.d_wdata = {32{8'h5A}};
      bus.d_addr  = 32'h0;
      settle();
      vectors++; if ({bus.pmem_write, bus.pmem_read} !== 2'b10) begin miscompares++; $display("FAIL wb_c1_strobes: got %b expected 10", {bus.pmem_write, bus.pmem_read}); end
      vectors++; if (bus.pmem_addr !== 32'h8000_0020) begin miscompares++; $display("FAIL wb_c1_addr: got %h expected 80000020", bus.pmem_addr); end
      vectors++; if (bus.pmem_wdata !== a5) begin miscompares++; $display("FAIL wb_c1_wdata: got %h expected %h", bus.pmem_wdata, a5); end
      vectors++; if (d_grant_cnt !== 32'd1) begin miscompares++; $display("FAIL wb_c1_dcnt: got %0d expected 1", d_grant_cnt); end
      step(); settle();   // cycle 2
      vectors++; if (bus.pmem_wdata !== a5) begin miscompares++; $display("FAIL wb_c2_wdata: got %h expected %h", bus.pmem_wdata, a5); end
      step();             // cycle 3: completion
      bus.pmem_resp = 1'b1;
      settle();
      vectors++; if ({bus.d_resp, bus.i_resp, bus.pmem_write} !== 3'b101) begin miscompares++; $display("FAIL wb_c3_resp: got %b expected 101", {bus.d_resp, bus.i_resp, bus.pmem_write}); end
      vectors++; if (bus.pmem_wdata !== a5) begin miscompares++; $display("FAIL wb_c3_wdata: got %h expected %h", bus.pmem_wdata, a5); end
      step();             // GAP
      bus.pmem_resp = 1'b0;
      bus.d_write   = 1'b0;
      settle();
      vectors++; if ({bus.d_resp, bus.pmem_write} !== 2'b00) begin miscompares++; $display("FAIL wb_gap: got %b expected 00", {bus.d_resp, bus.pmem_write}); end
      step();             // IDLE: illegal read+write is served as a write
      bus.d_read  = 1'b1;
      bus.d_write = 1'b1;
      bus.d_wdata = c3;
      step(); settle();
      vectors++; if ({bus.pmem_write, bus.pmem_read} !== 2'b10) begin miscompares++; $display("FAIL rw_as_write: got %b expected 10", {bus.pmem_write, bus.pmem_read}); end
      vectors++; if (bus.pmem_wdata !== c3) begin miscompares++; $display("FAIL rw_wdata: got %h expected %h", bus.pmem_wdata, c3); end
      step();
      bus.pmem_resp = 1'b1;
      settle();
      vectors++; if (bus.d_resp !== 1'b1) begin miscompares++; $display("FAIL rw_dresp: got %b expected 1", bus.d_resp); end
      step();
      idle_inputs();
      step();
   endtask

   task automatic test_spurious_resp();
      do_reset();
      bus.pmem_resp = 1'b1;   // in IDLE with nothing requested
      settle();
      vectors++; if ({bus.i_resp, bus.d_resp, busy} !== 3'b000) begin miscompares++; $display("FAIL sp_idle_resp: got %b expected 000", {bus.i_resp, bus.d_resp, busy}); end
      step();
      bus.pmem_resp = 1'b0;
      settle();
      vectors++; if ({busy, bus.pmem_read, bus.pmem_write} !== 3'b000) begin miscompares++; $display("FAIL sp_idle_state: got %b expected 000", {busy, bus.pmem_read, bus.pmem_write}); end
      vectors++; if ({i_grant_cnt, d_grant_cnt} !== 64'h0) begin miscompares++; $display("FAIL sp_idle_cnts: got %0d/%0d expected 0/0", i_grant_cnt, d_grant_cnt); end
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_0040;
      step();
      bus.pmem_resp = 1'b1;
      settle();
      vectors++; if (bus.i_resp !== 1'b1) begin miscompares++; $display("FAIL sp_txn_resp: got %b expected 1", bus.i_resp); end
      step();                 // GAP with pmem_resp still high
      bus.i_read = 1'b0;
      settle();
      vectors++; if ({bus.i_resp, bus.d_resp, busy} !== 3'b001) begin miscompares++; $display("FAIL sp_gap_resp: got %b expected 001", {bus.i_resp, bus.d_resp, busy}); end
      step();
      bus.pmem_resp = 1'b0;
      settle();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sp_gap_to_idle: got %b expected 0", busy); end
      vectors++; if ({i_grant_cnt, d_grant_cnt} !== {32'd1, 32'd0}) begin miscompares++; $display("FAIL sp_gap_cnts: got %0d/%0d expected 1/0", i_grant_cnt, d_grant_cnt); end
      step(); settle();
      vectors++; if (bus.pmem_read !== 1'b0) begin miscompares++; $display("FAIL sp_no_regrant: got %b expected 0", bus.pmem_read); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.d_read = 1'b1;
      bus.d_addr = 32'h0000_5000;
      step();                 // D_BUSY cycle 1
      step(); settle();       // D_BUSY cycle 2
      vectors++; if (bus.pmem_read !== 1'b1) begin miscompares++; $display("FAIL rm_dbusy: got %b expected 1", bus.pmem_read); end
      step();
      rst        = 1'b1;
      bus.d_read = 1'b0;
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_6000;
      settle();
      vectors++; if ({bus.pmem_read, busy, bus.d_resp} !== 3'b000) begin miscompares++; $display("FAIL rm_abort: got %b expected 000", {bus.pmem_read, busy, bus.d_resp}); end
      vectors++; if ({i_grant_cnt, d_grant_cnt} !== 64'h0) begin miscompares++; $display("FAIL rm_cnts: got %0d/%0d expected 0/0", i_grant_cnt, d_grant_cnt); end
      step();
      rst = 1'b0;
      step(); settle();
      vectors++; if ({bus.pmem_read, bus.pmem_write} !== 2'b10) begin miscompares++; $display("FAIL rm_igrant_strobe: got %b expected 10", {bus.pmem_read, bus.pmem_write}); end
      vectors++; if (bus.pmem_addr !== 32'h0000_6000) begin miscompares++; $display("FAIL rm_igrant_addr: got %h expected 00006000", bus.pmem_addr); end
      vectors++; if ({i_grant_cnt, d_grant_cnt} !== {32'd1, 32'd0}) begin miscompares++; $display("FAIL rm_igrant_cnts: got %0d/%0d expected 1/0", i_grant_cnt, d_grant_cnt); end
   endtask

   task automatic test_counter_wrap();
      do_reset();
      force dut.d_grant_cnt = 32'hFFFF_FFFF;
      step();
      release dut.d_grant_cnt;
      settle();
      vectors++; if (d_grant_cnt !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_preload: got %h expected ffffffff", d_grant_cnt); end
      bus.d_read = 1'b1;
      bus.d_addr = 32'h0000_7000;
      step(); settle();
      vectors++; if (d_grant_cnt !== 32'h0) begin miscompares++; $display("FAIL wrap_dcnt: got %h expected 00000000", d_grant_cnt); end
      vectors++; if (bus.pmem_read !== 1'b1) begin miscompares++; $display("FAIL wrap_strobe: got %b expected 1", bus.pmem_read); end
      step();
      bus.pmem_resp = 1'b1;
      settle();
      vectors++; if (bus.d_resp !== 1'b1) begin miscompares++; $display("FAIL wrap_dresp: got %b expected 1", bus.d_resp); end
      step();
      idle_inputs();
      step();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_read();
      test_contention();
      test_write_back();
      test_spurious_resp();
      test_reset_mid();
      test_counter_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
